// File: rtl/sequence_player_pkg.sv
// Shared simon package: playback state encoding, default step timing and widths.
// Reused by the game controller as well as the sequence player.
package sequence_player_pkg;

    localparam int unsigned LEN_W         = 5;
    localparam int unsigned SEQ_W         = 32;
    localparam int unsigned CNT_W         = 8;
    localparam int unsigned DEF_ON_TICKS  = 3;
    localparam int unsigned DEF_OFF_TICKS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_DONE = 2'd3
    } play_state_e;

    // Playback request captured when a start is accepted.
    typedef struct packed {
        logic [LEN_W-1:0] length;
        logic [SEQ_W-1:0] seq;
    } play_req_t;

endpackage

// File: rtl/sequence_player_if.sv
// Control/status bundle between the game controller (master) and the sequence player (slave).
interface sequence_player_if;
    import sequence_player_pkg::*;

    logic             start;
    logic             abort;
    logic             tick;
    logic [LEN_W-1:0] length;
    logic [SEQ_W-1:0] seq;
    logic             led_left;
    logic             led_right;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] pos;

    modport slave (
        input  start, abort, tick, length, seq,
        output led_left, led_right, busy, done, pos
    );

    modport master (
        output start, abort, tick, length, seq,
        input  led_left, led_right, busy, done, pos
    );

endinterface

// File: rtl/sequence_player_phase_timer.sv
// Tick counter for one ON or OFF phase; expire flags the tick that completes the phase.
module phase_timer
    import sequence_player_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             tick,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] r_count;

    assign expire = tick && (r_count == CNT_W'(limit - CNT_W'(1)));

    // Counter restarts on clear and on phase completion; otherwise advances per tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear || expire) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sequence_player.sv
// Plays a latched left/right LED sequence, one step per ON/OFF tick window.
module sequence_player
    import sequence_player_pkg::*;
#(
    parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
    parameter int unsigned OFF_TICKS = DEF_OFF_TICKS
) (
    input  logic              clk,
    input  logic              reset_n,
    sequence_player_if.slave  bus
);

    localparam logic [CNT_W-1:0] ON_LIMIT  = CNT_W'(ON_TICKS);
    localparam logic [CNT_W-1:0] OFF_LIMIT = CNT_W'(OFF_TICKS);

    play_state_e      r_state, w_state_next;
    play_req_t        r_req, w_req_next;
    logic [LEN_W-1:0] r_pos, w_pos_next;
    logic             r_led_left, r_led_right, r_busy, r_done;
    logic             w_led_left, w_led_right, w_busy, w_done;
    logic             w_step_bit;
    logic             w_expire;
    logic             w_clear;
    logic [CNT_W-1:0] w_limit;

    // Timer only runs while a step phase is active.
    assign w_clear = (r_state == ST_IDLE) || (r_state == ST_DONE) || bus.abort;
    assign w_limit = (r_state == ST_OFF) ? OFF_LIMIT : ON_LIMIT;

    phase_timer u_phase_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_clear),
        .tick    (bus.tick),
        .limit   (w_limit),
        .expire  (w_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_req       <= '0;
            r_pos       <= '0;
            r_led_left  <= 1'b0;
            r_led_right <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req       <= w_req_next;
            r_pos       <= w_pos_next;
            r_led_left  <= w_led_left;
            r_led_right <= w_led_right;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    // Next state plus next-cycle output values, so every output leaves a flop.
    always_comb begin
        w_state_next = r_state;
        w_req_next   = r_req;
        w_pos_next   = r_pos;

        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state_next = ST_ON;
                    w_req_next   = '{length: bus.length, seq: bus.seq};
                    w_pos_next   = '0;
                end
            end
            ST_ON: begin
                if (bus.abort) begin
                    w_state_next = ST_IDLE;
                    w_pos_next   = '0;
                end else if (w_expire) begin
                    w_state_next = ST_OFF;
                end
            end
            ST_OFF: begin
                if (bus.abort) begin
                    w_state_next = ST_IDLE;
                    w_pos_next   = '0;
                end else if (w_expire) begin
                    if (r_pos == r_req.length) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_ON;
                        w_pos_next   = r_pos + LEN_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                if (bus.abort) begin
                    w_pos_next = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_pos_next   = '0;
            end
        endcase

        w_step_bit  = w_req_next.seq[w_pos_next];
        w_led_right = (w_state_next == ST_ON) && w_step_bit;
        w_led_left  = (w_state_next == ST_ON) && !w_step_bit;
        w_busy      = (w_state_next != ST_IDLE);
        w_done      = (w_state_next == ST_DONE);
    end

    assign bus.led_left  = r_led_left;
    assign bus.led_right = r_led_right;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pos       = r_pos;

endmodule

// File: tb/tb_sequence_player.sv
// Directed and randomized playback runs checked against a tick-count model of the player.
module tb_sequence_player;

    localparam int unsigned T_ON  = 3;
    localparam int unsigned T_OFF = 2;
    localparam int unsigned T_P   = T_ON + T_OFF;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sequence_player_if u_if ();

    sequence_player #(.ON_TICKS(T_ON), .OFF_TICKS(T_OFF)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if)
    );

    int checks = 0;
    int errors = 0;

    // Model: ticks consumed since start fully determine step, phase and completion.
    bit          m_busy     = 1'b0;
    int          m_n        = 0;
    int          m_len      = 0;
    logic [31:0] m_seq      = '0;
    int          m_idle_pos = 0;

    int done_at, lit_cnt, right_cnt;

    function automatic int m_total();
        return (m_len + 1) * int'(T_P);
    endfunction

    function automatic logic [8:0] model_out();
        int  step;
        bit  lit;
        bit  b;
        if (!m_busy) return {4'b0000, 5'(m_idle_pos)};
        if (m_n == m_total()) return {2'b00, 1'b1, 1'b1, 5'(m_len)};
        step = m_n / int'(T_P);
        lit  = (m_n % int'(T_P)) < int'(T_ON);
        b    = m_seq[step];
        return {lit && !b, lit && b, 1'b1, 1'b0, 5'(step)};
    endfunction

    function automatic logic [8:0] dut_out();
        return {u_if.led_left, u_if.led_right, u_if.busy, u_if.done, u_if.pos};
    endfunction

    task automatic model_edge(input bit st, input bit ab, input bit tk,
                              input logic [4:0] len, input logic [31:0] sq);
        if (!m_busy) begin
            if (st && !ab) begin
                m_busy = 1'b1;
                m_n    = 0;
                m_len  = int'(len);
                m_seq  = sq;
            end
        end else if (m_n == m_total()) begin
            m_busy     = 1'b0;
            m_idle_pos = ab ? 0 : m_len;
        end else if (ab) begin
            m_busy     = 1'b0;
            m_idle_pos = 0;
        end else if (tk) begin
            m_n = m_n + 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit st, input bit ab, input bit tk,
                       input logic [4:0] len, input logic [31:0] sq, input string tag);
        u_if.start  = st;
        u_if.abort  = ab;
        u_if.tick   = tk;
        u_if.length = len;
        u_if.seq    = sq;
        @(posedge clk);
        #1;
        model_edge(st, ab, tk, len, sq);
        check(tag, 32'(dut_out()), 32'(model_out()));
    endtask

    task automatic tally(input int k);
        if (u_if.done && done_at == 0) done_at = k;
        if (u_if.led_left || u_if.led_right) lit_cnt++;
        if (u_if.led_right) right_cnt++;
    endtask

    // One playback from a start pulse until the model returns to idle; noise on unused inputs.
    task automatic play(input logic [4:0] len, input logic [31:0] sq, input int period,
                        input int abort_pct, input bit abort_in_done, input string tag);
        int k;
        bit tk, ab;
        done_at   = 0;
        lit_cnt   = 0;
        right_cnt = 0;
        cyc(1'b1, 1'b0, 1'b1, len, sq, tag);
        k = 1;
        tally(k);
        for (int c = 0; c < 4000 && m_busy; c++) begin
            tk = ((c % period) == period - 1);
            ab = (abort_pct > 0 && $urandom_range(99) < abort_pct)
                 || (abort_in_done && m_busy && m_n == m_total());
            cyc(1'($urandom_range(1)), ab, tk, 5'($urandom), $urandom, tag);
            k++;
            tally(k);
        end
        check({tag, "_drain"}, 32'(u_if.busy), 32'd0);
    endtask

    initial begin
        u_if.start  = 1'b0;
        u_if.abort  = 1'b0;
        u_if.tick   = 1'b0;
        u_if.length = '0;
        u_if.seq    = '0;
        reset_n     = 1'b0;
        #2;
        check("reset_outputs", 32'(dut_out()), 32'd0);
        repeat (2) @(posedge clk);
        #4;
        reset_n = 1'b1;

        // Start on the very first edge after reset release; R,L,R with tick high.
        play(5'd2, 32'h5, 1, 0, 1'b0, "req033");
        check("req033_done_at", 32'(done_at), 32'd16);
        check("req033_lit", 32'(lit_cnt), 32'd9);
        check("req033_right", 32'(right_cnt), 32'd6);
        cyc(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, "req033_idle_pos");
        check("req033_pos_hold", 32'(u_if.pos), 32'd2);

        play(5'd0, 32'hFFFF_FFFE, 1, 0, 1'b0, "req034");
        check("req034_done_at", 32'(done_at), 32'd6);
        check("req034_left", 32'(lit_cnt - right_cnt), 32'd3);

        play(5'd0, 32'h0, 4, 0, 1'b0, "req035");
        check("req035_done_at", 32'(done_at), 32'd21);
        check("req035_lit", 32'(lit_cnt), 32'd12);

        // Abort during step 1, then restart two cycles later.
        cyc(1'b1, 1'b0, 1'b1, 5'd3, 32'hA, "req036_start");
        repeat (6) cyc(1'b0, 1'b0, 1'b1, 5'd7, 32'h0, "req036_run");
        check("req036_step1", 32'(u_if.pos), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 5'd3, 32'hA, "req036_abort");
        check("req036_pos", 32'(u_if.pos), 32'd0);
        check("req036_done", 32'(u_if.done), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 5'd3, 32'hA, "req036_gap");
        play(5'd3, 32'hA, 1, 0, 1'b0, "req036_restart");
        check("req036_right", 32'(right_cnt), 32'd6);

        // Abort during the done cycle.
        play(5'd1, 32'h2, 1, 0, 1'b1, "req027");
        check("req027_done_seen", 32'(done_at), 32'd11);
        check("req027_pos", 32'(u_if.pos), 32'd0);

        // Asynchronous reset mid-ON, away from the clock edge.
        cyc(1'b1, 1'b0, 1'b1, 5'd4, 32'h1F, "req037_start");
        cyc(1'b0, 1'b0, 1'b1, 5'd4, 32'h1F, "req037_on");
        #2;
        reset_n = 1'b0;
        #1;
        check("req037_async", 32'(dut_out()), 32'd0);
        @(posedge clk);
        #3;
        reset_n    = 1'b1;
        m_busy     = 1'b0;
        m_idle_pos = 0;
        repeat (8) cyc(1'b0, 1'b0, 1'b1, 5'd4, 32'h1F, "req029_no_done");
        cyc(1'b1, 1'b1, 1'b1, 5'd4, 32'h1F, "req026_start_abort");
        check("req026_busy", 32'(u_if.busy), 32'd0);

        play(5'd31, 32'h8000_0000, 1, 0, 1'b0, "req038");
        check("req038_done_at", 32'(done_at), 32'd161);
        check("req038_lit", 32'(lit_cnt), 32'd96);
        check("req038_right", 32'(right_cnt), 32'd3);
        check("req038_pos", 32'(u_if.pos), 32'd31);

        for (int r = 0; r < 30; r++) begin
            play(5'($urandom_range(7)), $urandom, int'($urandom_range(1, 3)),
                 (r % 3 == 0) ? 2 : 0, 1'($urandom_range(1)), "rand_run");
            repeat ($urandom_range(2)) cyc(1'b0, 1'($urandom_range(1)), 1'b1,
                                           5'($urandom), $urandom, "rand_idle");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sequence_player.md
SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 Parameter ON_TICKS, default 3, meaning: tick pulses an LED stays lit per step (legal 1..255).
REQ-002 Parameter OFF_TICKS, default 2, meaning: tick pulses of dark gap after each step (legal 1..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request playback; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of playback.
REQ-007 tick  input  1  timebase enable, one-cycle pulses.
REQ-008 length  input  5  rounds won; steps played = length+1 (1..32).
REQ-009 seq  input  32  stored sequence; bit i = colour of step i (1 right, 0 left).
REQ-010 led_left  output  1  left LED drive, registered.
REQ-011 led_right  output  1  right LED drive, registered.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on playback completion.
REQ-014 pos  output  5  index of the step currently shown.

Function
REQ-015 FSM states: IDLE, ON, OFF, DONE.
REQ-016 IDLE + start=1 + abort=0 at an edge -> ON next cycle; length and seq latched at that edge; pos=0; tick counter=0.
REQ-017 In ON, led_right=seq_latched[pos], led_left=~seq_latched[pos]; in every other state both LEDs are 0.
REQ-018 Tick counter (8 bit) increments only on cycles with tick=1; cycles without tick hold it.
REQ-019 ON + tick=1 + counter==ON_TICKS-1 -> OFF, counter cleared.
REQ-020 OFF + tick=1 + counter==OFF_TICKS-1: if pos==length_latched -> DONE, else pos+1 and -> ON; counter cleared in both cases.
REQ-021 DONE lasts exactly one cycle with done=1, then -> IDLE; pos holds its last value in IDLE.
REQ-022 With tick tied high, each step occupies ON_TICKS+OFF_TICKS cycles; total busy time = (length+1)*(ON_TICKS+OFF_TICKS)+1 cycles.
REQ-023 length=31 plays all 32 steps; pos never wraps; bit 31 is reachable.
REQ-024 start while busy is ignored; input changes to length/seq during playback have no effect.
REQ-025 abort=1 in any non-IDLE state -> IDLE next cycle, LEDs 0, done stays 0, pos cleared to 0.
REQ-026 abort and start both high in IDLE: abort wins, stays IDLE.
REQ-027 abort in the DONE cycle: done is still asserted that cycle; next state IDLE.

Reset
REQ-028 reset_n=0 immediately forces IDLE, pos=0, counter=0, led_left=0, led_right=0, busy=0, done=0, latched length/seq=0, regardless of clk.
REQ-029 Reset asserted mid-playback discards the playback; no done pulse follows deassertion.
REQ-030 After reset_n rises, the first start takes effect on the first clk edge.

Structure
REQ-031 State encoding (IDLE/ON/OFF/DONE) and default ON_TICKS/OFF_TICKS live in the shared simon package, reused by the game controller.
REQ-032 Tick counting sits in one sub-module, phase_timer (inputs: clk, reset_n, clear, tick, limit; output: expire).

Verification
REQ-033 tick=1 always, length=2, seq=32'h5, start pulse -> LEDs R,L,R, each lit 3 cycles, 2 dark, done at cycle 16 after start, pos 0,1,2.
REQ-034 length=0, seq bit0=0 -> single left flash of 3 cycles, done pulse after 5 cycles busy, busy low next cycle.
REQ-035 tick every 4th cycle, length=0 -> ON lasts 12 cycles, OFF 8 cycles; LED and counter frozen between ticks.
REQ-036 abort during step 1 of length=3 run -> IDLE next cycle, LEDs 0, pos=0, no done; start 2 cycles later restarts at pos=0.
REQ-037 reset_n low mid-ON, off the clock edge -> outputs 0 before next edge; start+abort together in IDLE -> stays IDLE.
REQ-038 length=31, seq=32'h8000_0000 -> 31 left flashes then one right flash at pos=31, then done.
